// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch refill path: FSM encoding and AXI constants.
package if_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    FILL  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } refill_state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
endpackage

// File: rtl/icache_refill_ctrl.sv
// I-cache line refill controller: issues one AXI3 INCR burst per miss and streams beats
// into the line buffer; a flush turns the rest of the burst into a silent drain.
module icache_refill_ctrl
  import if_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int LINE_BYTES = 64,
  parameter int ADDR_W     = 32,
  localparam int BEATS     = LINE_BYTES * 8 / DATA_W,
  localparam int OFF_W     = $clog2(LINE_BYTES),
  localparam int IDX_W     = $clog2(BEATS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_req,
  input  logic [ADDR_W-1:0]       miss_addr,
  input  logic                    flush,
  output logic                    busy,
  output logic                    refill_we,
  output logic [IDX_W-1:0]        refill_idx,
  output logic [DATA_W-1:0]       refill_data,
  output logic [ADDR_W-OFF_W-1:0] refill_line,
  output logic                    refill_done,
  output logic                    refill_err,
  output logic [ADDR_W-1:0]       ARADDR,
  output logic [3:0]              ARLEN,
  output logic [2:0]              ARSIZE,
  output logic [1:0]              ARBURST,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_W-1:0]       RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RLAST,
  input  logic                    RVALID,
  output logic                    RREADY
);

  localparam logic [3:0] LEN_C  = 4'(BEATS - 1);
  localparam logic [2:0] SIZE_C = 3'($clog2(DATA_W / 8));

  refill_state_t           state;
  logic [ADDR_W-OFF_W-1:0] line;
  logic [IDX_W-1:0]        cnt;
  logic                    err;
  logic                    aborted;
  logic                    unused_off;

  assign unused_off = ^miss_addr[OFF_W-1:0];

  assign ARADDR      = {line, {OFF_W{1'b0}}};
  assign ARLEN       = LEN_C;
  assign ARSIZE      = SIZE_C;
  assign ARBURST     = BURST_INCR;
  assign refill_line = line;
  assign refill_idx  = cnt;
  assign refill_data = RDATA;
  assign busy        = (state != IDLE);
  // Writes still happen in the flush cycle itself; the line is simply never validated.
  assign refill_we   = (state == FILL) && RVALID;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      line        <= '0;
      cnt         <= '0;
      err         <= 1'b0;
      aborted     <= 1'b0;
      ARVALID     <= 1'b0;
      RREADY      <= 1'b0;
      refill_done <= 1'b0;
      refill_err  <= 1'b0;
    end else begin
      refill_done <= 1'b0;
      refill_err  <= 1'b0;
      case (state)
        IDLE: if (miss_req && !flush) begin
          line    <= miss_addr[ADDR_W-1:OFF_W];
          ARVALID <= 1'b1;
          err     <= 1'b0;
          aborted <= 1'b0;
          state   <= ADDR;
        end
        // AR cannot be withdrawn once raised, so a flush here is remembered until the handshake.
        ADDR: begin
          if (flush) aborted <= 1'b1;
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            cnt     <= '0;
            state   <= (aborted || flush) ? DRAIN : FILL;
          end
        end
        FILL: begin
          if (RVALID) begin
            cnt <= cnt + IDX_W'(1);
            if (RRESP != RESP_OKAY) err <= 1'b1;
          end
          if (RVALID && RLAST) begin
            RREADY <= 1'b0;
            if (flush) begin
              state <= IDLE;
            end else begin
              state       <= DONE;
              refill_done <= 1'b1;
              refill_err  <= err || (RRESP != RESP_OKAY);
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: if (RVALID && RLAST) begin
          RREADY <= 1'b0;
          state  <= IDLE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: directed and randomized bursts against a burst-level model,
// plus two extra instances for the wide-beat parameter points.
module tb_icache_refill_ctrl;

  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default instance
  logic        miss_req = 0, flush = 0, arready = 0, rlast = 0, rvalid = 0;
  logic [31:0] miss_addr = 0, rdata = 0;
  logic [1:0]  rresp = 0;
  logic        busy, refill_we, refill_done, refill_err, arvalid, rready;
  logic [3:0]  refill_idx, arlen;
  logic [31:0] refill_data, araddr;
  logic [25:0] refill_line;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  icache_refill_ctrl dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr), .flush(flush),
    .busy(busy), .refill_we(refill_we), .refill_idx(refill_idx), .refill_data(refill_data),
    .refill_line(refill_line), .refill_done(refill_done), .refill_err(refill_err),
    .ARADDR(araddr), .ARLEN(arlen), .ARSIZE(arsize), .ARBURST(arburst), .ARVALID(arvalid),
    .ARREADY(arready), .RDATA(rdata), .RRESP(rresp), .RLAST(rlast), .RVALID(rvalid),
    .RREADY(rready)
  );

  // sweep instances share stimulus except RLAST
  logic        s_miss = 0, s_flush = 0, s_arready = 0, s_rvalid = 0, rlast_b = 0, rlast_c = 0;
  logic [31:0] s_addr = 0;
  logic [63:0] s_rdata = 0;
  logic [1:0]  s_rresp = 0;

  logic        b_busy, b_we, b_done, b_err, b_arvalid, b_rready;
  logic [3:0]  b_idx, b_arlen;
  logic [63:0] b_data;
  logic [24:0] b_line;
  logic [31:0] b_araddr;
  logic [2:0]  b_arsize;
  logic [1:0]  b_arburst;

  icache_refill_ctrl #(.DATA_W(64), .LINE_BYTES(128)) dut_b (
    .clk(clk), .rst(rst), .miss_req(s_miss), .miss_addr(s_addr), .flush(s_flush),
    .busy(b_busy), .refill_we(b_we), .refill_idx(b_idx), .refill_data(b_data),
    .refill_line(b_line), .refill_done(b_done), .refill_err(b_err),
    .ARADDR(b_araddr), .ARLEN(b_arlen), .ARSIZE(b_arsize), .ARBURST(b_arburst),
    .ARVALID(b_arvalid), .ARREADY(s_arready), .RDATA(s_rdata), .RRESP(s_rresp),
    .RLAST(rlast_b), .RVALID(s_rvalid), .RREADY(b_rready)
  );

  logic        c_busy, c_we, c_done, c_err, c_arvalid, c_rready;
  logic [1:0]  c_idx;
  logic [3:0]  c_arlen;
  logic [63:0] c_data;
  logic [26:0] c_line;
  logic [31:0] c_araddr;
  logic [2:0]  c_arsize;
  logic [1:0]  c_arburst;

  icache_refill_ctrl #(.DATA_W(64), .LINE_BYTES(32)) dut_c (
    .clk(clk), .rst(rst), .miss_req(s_miss), .miss_addr(s_addr), .flush(s_flush),
    .busy(c_busy), .refill_we(c_we), .refill_idx(c_idx), .refill_data(c_data),
    .refill_line(c_line), .refill_done(c_done), .refill_err(c_err),
    .ARADDR(c_araddr), .ARLEN(c_arlen), .ARSIZE(c_arsize), .ARBURST(c_arburst),
    .ARVALID(c_arvalid), .ARREADY(s_arready), .RDATA(s_rdata), .RRESP(s_rresp),
    .RLAST(rlast_c), .RVALID(s_rvalid), .RREADY(c_rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One miss-to-finish transaction for the default instance. fl_beat/err_beat = -1 means none.
  // Expected behaviour is tracked only as "has the line been abandoned yet".
  task automatic run_fill(input logic [31:0] a, input int stall, input bit fl_addr,
                          input int fl_beat, input int err_beat, input bit poke);
    logic [31:0] d;
    logic [31:0] line_addr;
    bit          ab;
    ab        = fl_addr;
    line_addr = a & 32'hFFFF_FFC0;
    miss_addr = a;
    miss_req  = 1;
    #1 chk("idle_busy", 64'(busy), 64'd0);
    step;
    miss_req  = 0;
    miss_addr = $urandom;
    chk("addr_busy", 64'(busy), 64'd1);
    chk("arvalid", 64'(arvalid), 64'd1);
    chk("araddr", 64'(araddr), 64'(line_addr));
    chk("arlen", 64'(arlen), 64'd15);
    chk("arsize", 64'(arsize), 64'd2);
    chk("arburst", 64'(arburst), 64'd1);
    chk("refill_line", 64'(refill_line), 64'(a[31:6]));
    if (fl_addr) flush = 1;
    for (int s = 0; s < stall; s++) begin
      arready = 0;
      rvalid  = 1;
      #1;
      chk("ar_hold_v", 64'(arvalid), 64'd1);
      chk("ar_hold_a", 64'(araddr), 64'(line_addr));
      chk("no_early_r", 64'({rready, refill_we}), 64'd0);
      step;
      flush = 0;
    end
    rvalid  = 0;
    arready = 1;
    #1 chk("ar_hs_v", 64'(arvalid), 64'd1);
    chk("ar_hs_a", 64'(araddr), 64'(line_addr));
    step;
    arready = 0;
    flush   = 0;
    chk("ar_drop", 64'(arvalid), 64'd0);
    for (int b = 0; b < 16; b++) begin
      while ($urandom_range(0, 3) == 0) begin
        #1;
        chk("gap_we", 64'(refill_we), 64'd0);
        chk("gap_rready", 64'(rready), 64'd1);
        step;
      end
      d      = $urandom;
      rvalid = 1;
      rdata  = d;
      rresp  = (b == err_beat) ? 2'b10 : 2'b00;
      rlast  = (b == 15);
      flush  = (b == fl_beat);
      #1;
      chk("beat_we", 64'(refill_we), 64'(!ab));
      chk("beat_rready", 64'(rready), 64'd1);
      if (!ab) begin
        chk("beat_idx", 64'(refill_idx), 64'(b));
        chk("beat_data", 64'(refill_data), 64'(d));
      end
      if (b == fl_beat) ab = 1;
      step;
      rvalid = 0;
      rlast  = 0;
      flush  = 0;
      rresp  = 0;
    end
    if (ab) begin
      chk("abort_no_done", 64'(refill_done), 64'd0);
      chk("abort_idle", 64'(busy), 64'd0);
    end else begin
      if (poke) begin
        miss_req = 1;
        flush    = 1;
      end
      #1;
      chk("done", 64'(refill_done), 64'd1);
      chk("done_err", 64'(refill_err), 64'(err_beat >= 0));
      chk("done_busy", 64'(busy), 64'd1);
      step;
      miss_req = 0;
      flush    = 0;
      chk("done_pulse", 64'(refill_done), 64'd0);
      chk("err_pulse", 64'(refill_err), 64'd0);
      chk("post_idle", 64'(busy), 64'd0);
      if (poke) begin
        step;
        chk("miss_in_done_ignored", 64'(busy), 64'd0);
      end
    end
  endtask

  initial begin
    logic [31:0] sa;
    logic [63:0] d64;
    int          fb, eb;

    // reset with live-looking inputs
    miss_req = 1;
    rvalid   = 1;
    s_miss   = 1;
    step;
    step;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_we", 64'(refill_we), 64'd0);
    chk("rst_done", 64'(refill_done), 64'd0);
    chk("rst_err", 64'(refill_err), 64'd0);
    chk("rst_araddr", 64'(araddr), 64'd0);
    chk("rst_line", 64'(refill_line), 64'd0);
    chk("rst_idx", 64'(refill_idx), 64'd0);
    chk("rst_b_busy", 64'(b_busy), 64'd0);
    miss_req = 0;
    rvalid   = 0;
    s_miss   = 0;
    rst      = 0;
    step;

    // miss qualified by flush in IDLE is dropped
    miss_req  = 1;
    flush     = 1;
    miss_addr = 32'h0000_4000;
    step;
    miss_req = 0;
    flush    = 0;
    chk("idle_flush_miss", 64'(busy), 64'd0);
    step;

    run_fill(32'h0000_1234, 0, 0, -1, -1, 0);   // basic fill
    run_fill($urandom, 5, 0, -1, -1, 0);        // AR backpressure
    run_fill($urandom, 1, 0, 7, -1, 0);         // flush mid-fill
    run_fill($urandom, 2, 1, -1, -1, 0);        // flush while AR pending
    run_fill($urandom, 0, 1, -1, -1, 0);        // flush in handshake cycle
    run_fill($urandom, 0, 0, -1, 3, 1);         // error beat, flush/miss during DONE
    run_fill($urandom, 0, 0, 15, -1, 0);        // flush with RLAST
    for (int i = 0; i < 10; i++) begin
      fb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1;
      eb = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : -1;
      run_fill($urandom, int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), fb, eb,
               ($urandom_range(0, 1) == 1));
    end

    // reset mid-burst
    miss_addr = $urandom;
    miss_req  = 1;
    step;
    miss_req = 0;
    arready  = 1;
    step;
    arready = 0;
    rvalid  = 1;
    rdata   = $urandom;
    #1 chk("pre_rst_we", 64'(refill_we), 64'd1);
    rst = 1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_rready", 64'(rready), 64'd0);
    chk("mid_rst_we", 64'(refill_we), 64'd0);
    chk("mid_rst_araddr", 64'(araddr), 64'd0);
    chk("mid_rst_line", 64'(refill_line), 64'd0);
    step;
    rst    = 0;
    rvalid = 0;
    step;

    // parameter sweep: 64b x 128B (16 beats) and 64b x 32B (4 beats) in parallel
    sa     = $urandom;
    s_addr = sa;
    s_miss = 1;
    step;
    s_miss = 0;
    chk("b_arvalid", 64'(b_arvalid), 64'd1);
    chk("b_arlen", 64'(b_arlen), 64'd15);
    chk("b_arsize", 64'(b_arsize), 64'd3);
    chk("b_araddr", 64'(b_araddr), 64'(sa & 32'hFFFF_FF80));
    chk("c_arvalid", 64'(c_arvalid), 64'd1);
    chk("c_arlen", 64'(c_arlen), 64'd3);
    chk("c_arsize", 64'(c_arsize), 64'd3);
    chk("c_araddr", 64'(c_araddr), 64'(sa & 32'hFFFF_FFE0));
    s_arready = 1;
    step;
    s_arready = 0;
    for (int b = 0; b < 16; b++) begin
      d64      = {$urandom, $urandom};
      s_rvalid = 1;
      s_rdata  = d64;
      rlast_b  = (b == 15);
      rlast_c  = (b == 3);
      #1;
      chk("b_we", 64'(b_we), 64'd1);
      chk("b_idx", 64'(b_idx), 64'(b));
      chk("b_data", 64'(b_data), d64);
      chk("c_we", 64'(c_we), 64'(b < 4));
      if (b < 4) chk("c_idx", 64'(c_idx), 64'(b));
      if (b == 4) chk("c_done", 64'(c_done), 64'd1);
      step;
    end
    s_rvalid = 0;
    rlast_b  = 0;
    rlast_c  = 0;
    chk("b_done", 64'(b_done), 64'd1);
    chk("b_err", 64'(b_err), 64'd0);
    step;
    chk("b_idle", 64'(b_busy), 64'd0);
    chk("c_idle", 64'(c_busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, AXI read data width in bits (32 or 64).
REQ-002 SHALL have parameter LINE_BYTES, default 64, cache line size in bytes (power of 2).
REQ-003 SHALL have parameter ADDR_W, default 32, address width.
REQ-004 SHALL define derived constants:
  - BEATS = LINE_BYTES*8/DATA_W, which SHALL be ≤16 (AXI3 limit).
  - OFF_W = log2(LINE_BYTES).
  - IDX_W = log2(BEATS).
REQ-005 SHALL have port clk, input, 1, clock.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port miss_req, input, 1, cache lookup missed; request line fill.
REQ-008 SHALL have port miss_addr, input, ADDR_W, faulting fetch address.
REQ-009 SHALL have port flush, input, 1, abort outstanding refill (branch mispredict).
REQ-010 SHALL have port busy, output, 1, a refill is in progress.
REQ-011 SHALL have port refill_we, output, 1, write one beat into the line buffer/data array.
REQ-012 SHALL have port refill_idx, output, IDX_W, word index within the line for refill_data.
REQ-013 SHALL have port refill_data, output, DATA_W, refill beat data.
REQ-014 SHALL have port refill_line, output, ADDR_W-OFF_W, tag+index of the line being filled.
REQ-015 SHALL have port refill_done, output, 1, one-cycle pulse when the line completes and is validated.
REQ-016 SHALL have port refill_err, output, 1, one-cycle pulse with refill_done if any beat returned an RRESP error.
REQ-017 SHALL have the AXI3 read-channel ports:
  - ARADDR: output, ADDR_W.
  - ARLEN: output, 4.
  - ARSIZE: output, 3.
  - ARBURST: output, 2.
  - ARVALID: output, 1.
  - ARREADY: input, 1.
  - RDATA: input, DATA_W.
  - RRESP: input, 2.
  - RLAST: input, 1.
  - RVALID: input, 1.
  - RREADY: output, 1.

Function
REQ-018 SHALL implement the FSM states IDLE, ADDR, FILL, DRAIN and DONE.
REQ-019 In IDLE, a miss_req with flush low SHALL latch miss_addr[ADDR_W-1:OFF_W] and go to ADDR on the next cycle; miss_req SHALL be ignored outside IDLE.
REQ-020 In ADDR, the block SHALL:
  - drive ARVALID=1 and ARADDR={line,OFF_W'b0} (line-aligned);
  - drive ARLEN=BEATS-1, ARSIZE=log2(DATA_W/8) and ARBURST=2'b01 (INCR);
  - hold all AR signals stable until ARREADY.
REQ-021 When ARVALID&&ARREADY, the block SHALL deassert ARVALID and enter FILL on the next cycle.
REQ-022 In FILL, the block SHALL:
  - hold RREADY=1;
  - on each RVALID, assert refill_we in the same cycle (combinational from RVALID), with refill_data=RDATA and refill_idx=beat counter;
  - increment the beat counter.
REQ-023 The beat counter SHALL be IDX_W bits, reset to 0 on entering FILL, and wrap naturally after beat BEATS-1.
REQ-024 A handshaked beat with RRESP≠2'b00 SHALL set a sticky error flag, which SHALL be cleared on entering ADDR.
REQ-025 On a handshaked beat with RLAST=1 in FILL, the block SHALL go to DONE.
REQ-026 In DONE, the block SHALL pulse refill_done for one cycle, pulse refill_err if the error flag is set, and then return to IDLE.
REQ-027 flush in ADDR before the AR handshake completes SHALL NOT drop ARVALID (AXI rule); the block SHALL complete the handshake and go to DRAIN.
REQ-028 flush in FILL SHALL move the block to DRAIN on the next cycle; a beat accepted in the flush cycle SHALL still assert refill_we, since the line is not validated.
REQ-029 In DRAIN, the block SHALL hold RREADY=1, suppress refill_we, and on RVALID&&RLAST go to IDLE without refill_done.
REQ-030 flush in IDLE or DONE SHALL have no effect; refill_done SHALL still pulse in DONE.
REQ-031 A flush coincident with RLAST in FILL SHALL go to IDLE with no refill_done.
REQ-032 A miss_req in the cycle that returns the block to IDLE SHALL be accepted only on the following cycle.
REQ-033 busy SHALL be 1 in every state except IDLE.

Reset
REQ-034 While rst is high, the block SHALL:
  - be in state IDLE;
  - hold ARVALID, RREADY, refill_we, refill_done, refill_err and busy at 0;
  - hold ARADDR, refill_line, the beat counter and the error flag at 0.
REQ-035 Reset mid-burst SHALL abandon the burst; the AXI slave is reset in the same domain.

Structure
REQ-036 The FSM state encoding and the AXI constants (BURST_INCR, RESP_OKAY) SHALL reside in the shared package if_pkg.
REQ-037 The block SHALL be a single module with no sub-modules.

Verification
REQ-038 Bench SHALL cover a basic fill (defaults): miss_addr=0x0000_1234 -> ARADDR=0x0000_1200, ARLEN=15, ARSIZE=2; 16 beats -> refill_idx 0..15; refill_done 1 cycle after RLAST.
REQ-039 Bench SHALL cover ARREADY backpressure: ARREADY held low for 5 cycles -> ARVALID/ARADDR stable for all 6 cycles; no R-channel activity is accepted early.
REQ-040 Bench SHALL cover flush mid-fill: flush at beat 7 -> beats 8..15 are consumed with refill_we=0; IDLE after RLAST; no refill_done.
REQ-041 Bench SHALL cover flush during ADDR: ARVALID held until ARREADY; DRAIN consumes all 16 beats; busy=0 afterwards.
REQ-042 Bench SHALL cover the error response: RRESP=2'b10 on beat 3 -> refill_done and refill_err pulse together.
REQ-043 Bench SHALL cover a parameter sweep: DATA_W=64, LINE_BYTES=128 -> ARLEN=15, ARSIZE=3, 16 beats; DATA_W=64, LINE_BYTES=32 -> ARLEN=3.
